// File: rtl/mypipe_stream.sv
// Three-stage elastic pipe computing F = ((A+B)+(C-D))*D.
// Each stage is a valid/ready register slice; ready ripples back combinationally.
module mypipe_stream #(
  parameter int N = 10,
  parameter bit SIGNED = 1'b0,
  localparam int OW = 2*N+4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [N-1:0]  C,
  input  logic [N-1:0]  D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] F,
  output logic [1:0]    count
);

  logic          v1, v2, v3;
  logic          ready2, ready3;
  logic [N+1:0]  s1a, s1b;
  logic [N:0]    d1, d2;
  logic [N+2:0]  s2;
  logic [OW-1:0] f_q;
  logic [N:0]    ax, bx, cx, dx;
  logic [OW-1:0] px, py;

  function automatic logic [N:0] ext(input logic [N-1:0] x);
    return SIGNED ? {x[N-1], x} : {1'b0, x};
  endfunction

  assign ax = ext(A);
  assign bx = ext(B);
  assign cx = ext(C);
  assign dx = ext(D);

  assign ready3   = !v3 || out_ready;
  assign ready2   = !v2 || ready3;
  assign in_ready = !v1 || ready2;

  // Operands are sign-extended to OW; the low OW bits of the product are exact.
  assign px = {{(OW-N-3){s2[N+2]}}, s2};
  assign py = {{(OW-N-1){d2[N]}}, d2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      s1a <= '0;
      s1b <= '0;
      d1  <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1a <= {ax[N], ax} + {bx[N], bx};
        s1b <= {cx[N], cx} - {dx[N], dx};
        d1  <= dx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      s2 <= '0;
      d2 <= '0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        s2 <= {s1a[N+1], s1a} + {s1b[N+1], s1b};
        d2 <= d1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      f_q <= '0;
    end else if (ready3) begin
      v3 <= v2;
      if (v2) f_q <= px * py;
    end
  end

  assign out_valid = v3;
  assign F         = f_q;
  assign count     = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

endmodule

// File: tb/tb_mypipe_stream.sv
// Scoreboard bench for mypipe_stream: unsigned N=10 and signed N=8 instances
// against an integer reference of ((A+B)+(C-D))*D.
module tb_mypipe_stream;

  logic clk, rst_n;

  logic       iv0, ir0, ov0, or0;
  logic [9:0] a0, b0, c0, d0;
  logic [23:0] f0;
  logic [1:0] cnt0;

  logic       iv1, ir1, ov1, or1;
  logic [7:0] a1, b1, c1, d1;
  logic [19:0] f1;
  logic [1:0] cnt1;

  int checks = 0;
  int fails  = 0;
  int pops0  = 0;
  longint sb0[$];
  longint sb1[$];

  mypipe_stream #(.N(10), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .out_valid(ov0), .out_ready(or0),
    .F(f0), .count(cnt0)
  );

  mypipe_stream #(.N(8), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .out_valid(ov1), .out_ready(or1),
    .F(f1), .count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint model(input longint a, b, c, d);
    return ((a + b) + (c - d)) * d;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitors sample 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (iv0 && ir0)
        sb0.push_back(model(longint'(a0), longint'(b0),
                            longint'(c0), longint'(d0)));
      if (ov0 && or0) begin
        pops0++;
        if (sb0.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL u0_extra: got %0d expected none",
                   longint'($signed(f0)));
        end else
          chk("u0_F", longint'($signed(f0)), sb0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (iv1 && ir1)
        sb1.push_back(model(longint'($signed(a1)), longint'($signed(b1)),
                            longint'($signed(c1)), longint'($signed(d1))));
      if (ov1 && or1) begin
        if (sb1.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL u1_extra: got %0d expected none",
                   longint'($signed(f1)));
        end else
          chk("u1_F", longint'($signed(f1)), sb1.pop_front());
      end
    end
  end

  task automatic send0(input int a, b, c, d);
    int t;
    @(negedge clk);
    a0 = 10'(a); b0 = 10'(b); c0 = 10'(c); d0 = 10'(d);
    iv0 = 1'b1;
    #2;
    t = 0;
    while (!ir0 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!ir0) chk("u0_send_timeout", 0, 1);
  endtask

  task automatic send1(input int a, b, c, d);
    int t;
    @(negedge clk);
    a1 = 8'(a); b1 = 8'(b); c1 = 8'(c); d1 = 8'(d);
    iv1 = 1'b1;
    #2;
    t = 0;
    while (!ir1 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!ir1) chk("u1_send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv0 = 1'b0;
      iv1 = 1'b0;
    end
  endtask

  int ta[5] = '{10, 10, 20, 15, 8};
  int tb[5] = '{12, 10, 11, 10, 15};
  int tc[5] = '{6, 5, 1, 8, 5};
  int td[5] = '{3, 3, 4, 2, 0};

  initial begin
    int p;
    bit acc;
    longint held;
    rst_n = 1'b0;
    iv0 = 0; or0 = 1; a0 = 0; b0 = 0; c0 = 0; d0 = 0;
    iv1 = 0; or1 = 1; a1 = 0; b1 = 0; c1 = 0; d1 = 0;
    #12;
    chk("rst_out_valid", ov0, 0);
    chk("rst_F", f0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_F_signed", f1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_in_ready", ir0, 1);

    // Back-to-back stream: results appear 3 samples after the first drive.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 5) begin
        a0 = 10'(ta[i]); b0 = 10'(tb[i]); c0 = 10'(tc[i]); d0 = 10'(td[i]);
        iv0 = 1'b1;
      end else iv0 = 1'b0;
      #2;
      chk("b2b_in_ready", ir0, 1);
      chk("b2b_latency", ov0, (i >= 3 && i < 8) ? 1 : 0);
    end

    // Back-pressure: fourth set must wait while F is held.
    or0 = 1'b0;
    for (int i = 0; i < 3; i++) send0(ta[i], tb[i], tc[i], td[i]);
    @(negedge clk);
    a0 = 10'(ta[3]); b0 = 10'(tb[3]); c0 = 10'(tc[3]); d0 = 10'(td[3]);
    iv0 = 1'b1;
    held = model(ta[0], tb[0], tc[0], td[0]);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_in_ready", ir0, 0);
      chk("bp_count", cnt0, 3);
      chk("bp_out_valid", ov0, 1);
      chk("bp_F_held", longint'($signed(f0)), held);
      @(negedge clk);
    end
    or0 = 1'b1;
    idle(6);

    // Bubbles
    p = pops0;
    send0(10, 20, 5, 3);
    idle(1);
    send0(10, 10, 30, 1);
    idle(6);
    chk("bubble_results", pops0 - p, 2);

    // Full pipe with out_ready=1 keeps accepting every cycle.
    p = pops0;
    or0 = 1'b0;
    for (int i = 0; i < 3; i++)
      send0($urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      or0 = 1'b1;
      iv0 = 1'b1;
      a0 = 10'($urandom); b0 = 10'($urandom);
      c0 = 10'($urandom); d0 = 10'($urandom);
      #2;
      chk("full_in_ready", ir0, 1);
      chk("full_count", cnt0, 3);
    end
    idle(6);
    chk("full_results", pops0 - p, 13);

    // Signed instance
    send1(-5, 2, -10, -3);
    send1(127, 127, 127, -128);
    send1(-128, -128, -128, 127);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      or1 = ($urandom_range(0, 3) != 0);
      iv1 = $urandom_range(0, 1);
      if (iv1) begin
        a1 = 8'($urandom); b1 = 8'($urandom);
        c1 = 8'($urandom); d1 = 8'($urandom);
      end
      #2;
      if (iv1 && !ir1) begin
        while (!ir1) begin
          @(negedge clk);
          or1 = 1'b1;
          #2;
        end
      end
    end
    or1 = 1'b1;
    idle(6);

    // Random traffic with random back-pressure; operands held until taken.
    acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!iv0 || acc) begin
        iv0 = $urandom_range(0, 1);
        a0 = 10'($urandom); b0 = 10'($urandom);
        c0 = 10'($urandom); d0 = 10'($urandom);
      end
      or0 = ($urandom_range(0, 3) != 0);
      #2;
      acc = iv0 && ir0;
    end
    or0 = 1'b1;
    idle(6);

    // Asynchronous reset with two sets in flight.
    send0(100, 200, 300, 400);
    send0(5, 6, 7, 8);
    @(negedge clk);
    iv0 = 1'b0;
    #2;
    chk("prerst_count", cnt0, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", ov0, 0);
    chk("async_count", cnt0, 0);
    chk("async_F", f0, 0);
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_in_ready", ir0, 1);
    send0(30, 1, 2, 4);
    @(negedge clk);
    iv0 = 1'b0;
    #2;
    chk("post_rst_lat1", ov0, 0);
    @(negedge clk);
    #2;
    chk("post_rst_lat2", ov0, 0);
    @(negedge clk);
    #2;
    chk("post_rst_lat3", ov0, 1);
    idle(4);

    chk("u0_scoreboard_empty", sb0.size(), 0);
    chk("u1_scoreboard_empty", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
